// File: rtl/mc_axi_resp_emulator_if.sv
// Request/response bundle between the AFU (master) and the MC-side responder (slave).
// Write data and strobes travel with AW, so there is no separate W channel.
`timescale 1ns/1ps
interface mc_axi_resp_emulator_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 52,
    parameter int ID_W   = 8
);
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic [1:0]          rresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    modport master (
        output arvalid, arid, araddr, awvalid, awid, awaddr, wdata, wstrb, rready, bready,
        input  arready, awready, rvalid, rid, rdata, rlast, rresp, bvalid, bid, bresp
    );

    modport slave (
        input  arvalid, arid, araddr, awvalid, awid, awaddr, wdata, wstrb, rready, bready,
        output arready, awready, rvalid, rid, rdata, rlast, rresp, bvalid, bid, bresp
    );
endinterface

// File: rtl/mc_axi_resp_emulator.sv
// Single-channel memory-controller stand-in: byte-lane line memory plus an in-order
// response queue whose head issues once its per-entry latency has elapsed.
`timescale 1ns/1ps
module mc_axi_resp_emulator #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 52,
    parameter int ID_W      = 8,
    parameter int MEM_LINES = 1024,
    parameter int Q_DEPTH   = 16
) (
    input  logic                        afu_clk,
    input  logic                        afu_rst,
    input  logic [9:0]                  cfg_latency,
    mc_axi_resp_emulator_if.slave       axi
);
    localparam int LINE_W = $clog2(MEM_LINES);
    localparam int PTR_W  = $clog2(Q_DEPTH);
    localparam int BYTES  = DATA_W / 8;

    logic [PTR_W:0]     count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, fill_slot_reg;
    logic [15:0]        cycle_cnt_reg;
    logic               fill_valid_reg;

    logic               q_is_wr [Q_DEPTH];
    logic [ID_W-1:0]    q_id    [Q_DEPTH];
    logic [DATA_W-1:0]  q_data  [Q_DEPTH];
    logic [15:0]        q_stamp [Q_DEPTH];
    logic [9:0]         q_lat   [Q_DEPTH];

    logic               has_space, ar_acc, aw_acc, push, pop;
    logic [ADDR_W-1:0]  line_addr;
    logic [LINE_W-1:0]  line_idx;
    logic [9:0]         lat_eff;
    logic [15:0]        head_age;
    logic               head_due, rvalid_int, bvalid_int;
    logic [DATA_W-1:0]  rd_line;
    logic               unused_addr_bits;

    // Ready is a pure function of occupancy; a same-cycle pop never frees a slot.
    assign has_space   = count_reg < (PTR_W + 1)'(Q_DEPTH);
    assign axi.arready = has_space && !afu_rst;
    assign axi.awready = has_space && !afu_rst && !axi.arvalid;

    assign ar_acc    = axi.arvalid && axi.arready;
    assign aw_acc    = axi.awvalid && axi.awready;
    assign push      = ar_acc || aw_acc;
    assign line_addr = ar_acc ? axi.araddr : axi.awaddr;
    assign line_idx  = line_addr[6 +: LINE_W];
    assign lat_eff   = (cfg_latency < 10'd2) ? 10'd2 : cfg_latency;
    assign unused_addr_bits = ^{line_addr[ADDR_W-1:6+LINE_W], line_addr[5:0]};

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_LINES];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge afu_clk) begin
                if (aw_acc && axi.wstrb[gi]) begin
                    lane_mem[line_idx] <= axi.wdata[gi*8 +: 8];
                end
                if (ar_acc) begin
                    lane_rd_reg <= lane_mem[line_idx];
                end
            end

            assign rd_line[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    // Age is computed modulo 2^16 so the compare survives counter wrap.
    assign head_age   = cycle_cnt_reg - q_stamp[rd_ptr_reg];
    assign head_due   = !afu_rst && (count_reg != '0) && (head_age >= 16'(q_lat[rd_ptr_reg]));
    assign rvalid_int = head_due && !q_is_wr[rd_ptr_reg];
    assign bvalid_int = head_due &&  q_is_wr[rd_ptr_reg];
    assign pop        = (rvalid_int && axi.rready) || (bvalid_int && axi.bready);

    assign axi.rvalid = rvalid_int;
    assign axi.rlast  = rvalid_int;
    assign axi.rid    = q_id[rd_ptr_reg];
    assign axi.rdata  = q_data[rd_ptr_reg];
    assign axi.rresp  = 2'b00;
    assign axi.bvalid = bvalid_int;
    assign axi.bid    = q_id[rd_ptr_reg];
    assign axi.bresp  = 2'b00;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge afu_clk) begin
        if (afu_rst) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            cycle_cnt_reg  <= '0;
            fill_valid_reg <= 1'b0;
        end else begin
            cycle_cnt_reg  <= cycle_cnt_reg + 16'd1;
            count_reg      <= count_next;
            fill_valid_reg <= push;
            if (push) begin
                wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                fill_slot_reg <= wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Metadata lands at acceptance; line data follows one cycle later from the RAM register.
    always_ff @(posedge afu_clk) begin
        if (push) begin
            q_is_wr[wr_ptr_reg] <= aw_acc;
            q_id[wr_ptr_reg]    <= ar_acc ? axi.arid : axi.awid;
            q_stamp[wr_ptr_reg] <= cycle_cnt_reg;
            q_lat[wr_ptr_reg]   <= lat_eff;
        end
        if (fill_valid_reg) begin
            q_data[fill_slot_reg] <= rd_line;
        end
    end
endmodule

// File: tb/tb_mc_axi_resp_emulator.sv
// Directed bench for mc_axi_resp_emulator: a vector table of single transactions
// followed by hand-written multi-cycle sequences (reset, collision, full queue, latency change, wrap).
`timescale 1ns/1ps
module tb_mc_axi_resp_emulator;
    logic       afu_clk;
    logic       afu_rst;
    logic [9:0] cfg_latency;
    int         n_cmp;
    int         n_err;

    mc_axi_resp_emulator_if #(.DATA_W(512), .ADDR_W(52), .ID_W(8)) axi ();

    mc_axi_resp_emulator #(
        .DATA_W(512), .ADDR_W(52), .ID_W(8), .MEM_LINES(1024), .Q_DEPTH(16)
    ) dut (
        .afu_clk     (afu_clk),
        .afu_rst     (afu_rst),
        .cfg_latency (cfg_latency),
        .axi         (axi)
    );

    initial afu_clk = 1'b0;
    always #5 afu_clk = ~afu_clk;

    typedef struct {
        bit           is_wr;
        logic [7:0]   id;
        logic [51:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic [9:0]   lat_cfg;
        int           exp_lat;
        logic [511:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge afu_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!(axi.rvalid || axi.bvalid) && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        afu_rst = 1'b1;
        repeat (3) tick();
        afu_rst = 1'b0;
    endtask

    // Read A with latency 50, then read B with latency 3: B must still follow A.
    task automatic lat_change(input string tag);
        int n;
        axi.rready  = 1'b1;
        cfg_latency = 10'd50;
        axi.arvalid = 1'b1;
        axi.arid    = 8'h50;
        axi.araddr  = 52'h40;
        tick();
        cfg_latency = 10'd3;
        axi.arid    = 8'h51;
        tick();
        axi.arvalid = 1'b0;
        cfg_latency = 10'd10;
        wait_valid(1100, n);
        chk({tag, "_first_lat"}, n + 2, 50);
        chk({tag, "_first_rid"}, axi.rid, 8'h50);
        chk({tag, "_first_rdata"}, axi.rdata, {64{8'hA5}});
        $display("txn %s first rid=%02h lat=%0d", tag, axi.rid, n + 2);
        tick();
        chk({tag, "_second_rvalid"}, axi.rvalid, 1'b1);
        chk({tag, "_second_rid"}, axi.rid, 8'h51);
        $display("txn %s second rid=%02h lat=%0d", tag, axi.rid, n + 3);
        tick();
        chk({tag, "_drained"}, axi.rvalid, 1'b0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{1'b1, 8'h05, 52'h40,    {64{8'hA5}}, {64{1'b1}}, 10'd10,   10,   '0};
        vecs[1] = '{1'b0, 8'h06, 52'h40,    '0,          '0,         10'd10,   10,   {64{8'hA5}}};
        vecs[2] = '{1'b1, 8'h10, 52'h80,    {64{8'hFF}}, {64{1'b1}}, 10'd0,    2,    '0};
        vecs[3] = '{1'b1, 8'h11, 52'h80,    {64{8'h00}}, 64'hF,      10'd1,    2,    '0};
        vecs[4] = '{1'b0, 8'h12, 52'h80,    '0,          '0,         10'd3,    3,    {{60{8'hFF}}, {4{8'h00}}}};
        vecs[5] = '{1'b0, 8'h13, 52'h7F,    '0,          '0,         10'd5,    5,    {64{8'hA5}}};
        vecs[6] = '{1'b0, 8'h14, 52'h10040, '0,          '0,         10'd2,    2,    {64{8'hA5}}};
        vecs[7] = '{1'b1, 8'h20, 52'hFFC0,  {64{8'h3C}}, {64{1'b1}}, 10'd1023, 1023, '0};
        vecs[8] = '{1'b0, 8'h21, 52'hFFC0,  '0,          '0,         10'd7,    7,    {64{8'h3C}}};

        afu_rst     = 1'b1;
        cfg_latency = 10'd10;
        axi.arvalid = 1'b1;
        axi.arid    = 8'h01;
        axi.araddr  = 52'h40;
        axi.awvalid = 1'b0;
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.rready  = 1'b1;
        axi.bready  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_arready", axi.arready, 1'b0);
            chk("rst_awready", axi.awready, 1'b0);
            chk("rst_rvalid", axi.rvalid, 1'b0);
            chk("rst_bvalid", axi.bvalid, 1'b0);
        end
        afu_rst     = 1'b0;
        axi.arvalid = 1'b0;
        #1;
        chk("post_rst_arready", axi.arready, 1'b1);
        chk("post_rst_awready", axi.awready, 1'b1);
        chk("post_rst_rlast", axi.rlast, 1'b0);
        $display("txn reset released arready=%0b", axi.arready);

        for (int i = 0; i < 9; i++) begin
            cfg_latency = vecs[i].lat_cfg;
            if (vecs[i].is_wr) begin
                axi.awvalid = 1'b1;
                axi.awid    = vecs[i].id;
                axi.awaddr  = vecs[i].addr;
                axi.wdata   = vecs[i].data;
                axi.wstrb   = vecs[i].strb;
                #1;
                chk("vec_awready", axi.awready, 1'b1);
            end else begin
                axi.arvalid = 1'b1;
                axi.arid    = vecs[i].id;
                axi.araddr  = vecs[i].addr;
                #1;
                chk("vec_arready", axi.arready, 1'b1);
            end
            tick();
            axi.arvalid = 1'b0;
            axi.awvalid = 1'b0;
            wait_valid(1100, n);
            chk("vec_latency", n + 1, vecs[i].exp_lat);
            chk("vec_bvalid", axi.bvalid, vecs[i].is_wr);
            chk("vec_rvalid", axi.rvalid, !vecs[i].is_wr);
            if (vecs[i].is_wr) begin
                chk("vec_bid", axi.bid, vecs[i].id);
                chk("vec_bresp", axi.bresp, 2'b00);
            end else begin
                chk("vec_rid", axi.rid, vecs[i].id);
                chk("vec_rdata", axi.rdata, vecs[i].exp_data);
                chk("vec_rlast", axi.rlast, 1'b1);
                chk("vec_rresp", axi.rresp, 2'b00);
            end
            $display("txn vec%0d %s id=%02h lat=%0d", i, vecs[i].is_wr ? "WR" : "RD", vecs[i].id, n + 1);
            tick();
            chk("vec_idle", axi.rvalid | axi.bvalid, 1'b0);
        end

        // AR and AW together at minimum latency: AR wins, AW follows a cycle later.
        cfg_latency = 10'd0;
        axi.arvalid = 1'b1;
        axi.arid    = 8'h60;
        axi.araddr  = 52'h40;
        axi.awvalid = 1'b1;
        axi.awid    = 8'h61;
        axi.awaddr  = 52'h100;
        axi.wdata   = {64{8'h77}};
        axi.wstrb   = {64{1'b1}};
        #1;
        chk("col_arready", axi.arready, 1'b1);
        chk("col_awready", axi.awready, 1'b0);
        tick();
        axi.arvalid = 1'b0;
        #1;
        chk("col_awready_later", axi.awready, 1'b1);
        tick();
        axi.awvalid = 1'b0;
        chk("col_rvalid", axi.rvalid, 1'b1);
        chk("col_rid", axi.rid, 8'h60);
        chk("col_bvalid_early", axi.bvalid, 1'b0);
        $display("txn collision rid=%02h", axi.rid);
        tick();
        chk("col_bvalid", axi.bvalid, 1'b1);
        chk("col_bid", axi.bid, 8'h61);
        chk("col_rvalid_after", axi.rvalid, 1'b0);
        $display("txn collision bid=%02h", axi.bid);
        tick();
        chk("col_idle", axi.rvalid | axi.bvalid, 1'b0);

        // Fill the queue with reads under back-pressure, then drain it.
        cfg_latency = 10'd2;
        axi.rready  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            axi.arvalid = 1'b1;
            axi.arid    = 8'h30 + 8'(i);
            axi.araddr  = 52'h40;
            #1;
            chk("full_fill_arready", axi.arready, 1'b1);
            tick();
        end
        axi.arid = 8'h4F;
        chk("full_arready_17", axi.arready, 1'b0);
        tick();
        chk("full_arready_hold", axi.arready, 1'b0);
        axi.arvalid = 1'b0;
        repeat (3) tick();
        chk("full_stall_rvalid", axi.rvalid, 1'b1);
        chk("full_stall_rid", axi.rid, 8'h30);
        axi.rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_rvalid", axi.rvalid, 1'b1);
            chk("drain_rid", axi.rid, 8'h30 + 8'(i));
            if (i == 0) chk("drain_arready_before_pop", axi.arready, 1'b0);
            if (i == 1) chk("drain_arready_after_pop", axi.arready, 1'b1);
            $display("txn drain rid=%02h", axi.rid);
            tick();
        end
        chk("drain_done", axi.rvalid, 1'b0);

        lat_change("latchg");

        do_reset();
        repeat (65510) tick();
        lat_change("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
